bullet_engine: RTL and testbench

//   Consumes keypad player column (playPos) and fire toggle; spawns bullets above the player
//   and advances them one row toward the top each step tick. Holds a fixed pool of bullet

---
 rtl/raiden_pkg.sv | 21 ++
 rtl/tick_gen.sv | 26 ++
 rtl/bullet_engine.sv | 137 +++++++++++++
 tb/tb_bullet_engine.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/raiden_pkg.sv
// Playfield geometry and bullet record shared by the bullet engine, display
// and collision stages.
package raiden_pkg;

  localparam int ROWS  = 16;
  localparam int COLS  = 8;
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = 3;

  typedef struct packed {
    logic             valid;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } bullet_t;

  // Bullets appear one row above the player row.
  function automatic logic [ROW_W-1:0] spawn_row();
    return ROW_W'(ROWS - 2);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle movement tick every STEP_DIV clocks.
module tick_gen #(
  parameter int STEP_DIV = 2500000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int CNT_W = $clog2(STEP_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic             wrap;

  assign wrap   = (cnt_q == CNT_W'(STEP_DIV - 1));
  assign tick_o = wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/bullet_engine.sv
// Bullet pool: spawns a bullet above the player on each fire toggle, moves
// bullets upward every tick and serves a registered row-scan port.
module bullet_engine
  import raiden_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int STEP_DIV  = 2500000,
  parameter int COOLDOWN  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      playPos,
  input  logic            fire,
  input  logic [3:0]      scan_row,
  output logic [COLS-1:0] row_bits,
  output logic [3:0]      active_cnt,
  output logic            shot_drop
);

  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic                          tick;
  logic                          req;
  logic                          fire_q;
  bullet_t [NUM_SLOTS-1:0]       slots_q, slots_d;
  logic [CD_W-1:0]               cd_q, cd_d;
  logic [COLS-1:0]               row_bits_q, row_bits_d;
  logic [3:0]                    active_cnt_q, active_cnt_d;
  logic                          shot_drop_q, shot_drop_d;
  logic                          free_found;
  logic [IDX_W-1:0]              free_idx;
  logic                          scan_ok;

  tick_gen #(
    .STEP_DIV(STEP_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst),
    .tick_o(tick)
  );

  // The keypad flips fire once per key hit, so both edges are requests.
  assign req = fire ^ fire_q;

  // Freeness is judged on the start-of-cycle state: slots retiring this
  // cycle cannot be refilled until the next one.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slots_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    slots_d     = slots_q;
    cd_d        = cd_q;
    shot_drop_d = 1'b0;
    if (tick) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (slots_q[i].valid) begin
          if (slots_q[i].row == '0) begin
            slots_d[i].valid = 1'b0;
          end else begin
            slots_d[i].row = slots_q[i].row - 1'b1;
          end
        end
      end
      if (cd_q != '0) begin
        cd_d = cd_q - 1'b1;
      end
    end
    if (req) begin
      if (cd_q == '0 && free_found) begin
        slots_d[free_idx].valid = 1'b1;
        slots_d[free_idx].row   = spawn_row();
        slots_d[free_idx].col   = playPos;
        cd_d                    = CD_W'(COOLDOWN);
      end else begin
        shot_drop_d = 1'b1;
      end
    end
  end

  always_comb begin
    active_cnt_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      active_cnt_d = active_cnt_d + {3'b000, slots_d[i].valid};
    end
  end

  assign scan_ok = (int'(scan_row) < ROWS);

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      logic hit;
      always_comb begin
        hit = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
          if (slots_q[s].valid && int'(slots_q[s].row) == int'(scan_row) &&
              int'(slots_q[s].col) == gi) begin
            hit = 1'b1;
          end
        end
      end
      assign row_bits_d[gi] = hit & scan_ok;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fire_q       <= 1'b0;
      slots_q      <= '0;
      cd_q         <= '0;
      row_bits_q   <= '0;
      active_cnt_q <= '0;
      shot_drop_q  <= 1'b0;
    end else begin
      fire_q       <= fire;
      slots_q      <= slots_d;
      cd_q         <= cd_d;
      row_bits_q   <= row_bits_d;
      active_cnt_q <= active_cnt_d;
      shot_drop_q  <= shot_drop_d;
    end
  end

  assign row_bits   = row_bits_q;
  assign active_cnt = active_cnt_q;
  assign shot_drop  = shot_drop_q;

endmodule

// File: tb/tb_bullet_engine.sv
// Directed bench for bullet_engine with a per-cycle expectation queue fed by a
// small reference model of the bullet pool.
module tb_bullet_engine;

  localparam int NUM_SLOTS = 4;
  localparam int STEP_DIV  = 4;
  localparam int COOLDOWN  = 2;
  localparam int ROWS      = 16;
  localparam int COLS      = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [2:0]      playPos = 3'd0;
  logic            fire = 1'b0;
  logic [3:0]      scan_row = 4'd0;
  logic [COLS-1:0] row_bits;
  logic [3:0]      active_cnt;
  logic            shot_drop;

  bullet_engine #(
    .NUM_SLOTS(NUM_SLOTS),
    .STEP_DIV (STEP_DIV),
    .COOLDOWN (COOLDOWN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .playPos   (playPos),
    .fire      (fire),
    .scan_row  (scan_row),
    .row_bits  (row_bits),
    .active_cnt(active_cnt),
    .shot_drop (shot_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [COLS-1:0] rb;
    logic [3:0]      ac;
    logic            sd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int   m_valid[NUM_SLOTS];
  int   m_row[NUM_SLOTS];
  int   m_col[NUM_SLOTS];
  int   m_div;
  int   m_cd;
  logic m_fireq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int s = 0; s < NUM_SLOTS; s++) begin
      m_valid[s] = 0; m_row[s] = 0; m_col[s] = 0;
    end
    m_div = 0; m_cd = 0; m_fireq = 1'b0;
  endtask

  // Expected outputs after the coming edge, given the inputs now applied.
  task automatic model_step(output exp_t e);
    int  free_s, cd0, cnt;
    bit  tk, rq;
    e.rb = '0;
    for (int s = 0; s < NUM_SLOTS; s++)
      if (m_valid[s] != 0 && m_row[s] == int'(scan_row) && m_col[s] < COLS) e.rb[m_col[s]] = 1'b1;
    tk = (m_div == STEP_DIV - 1);
    m_div = tk ? 0 : m_div + 1;
    rq = (fire != m_fireq);
    m_fireq = fire;
    free_s = -1;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) if (m_valid[s] == 0) free_s = s;
    cd0 = m_cd;
    if (tk) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (m_valid[s] != 0) begin
          if (m_row[s] == 0) m_valid[s] = 0;
          else m_row[s] = m_row[s] - 1;
        end
      end
      if (m_cd > 0) m_cd = m_cd - 1;
    end
    e.sd = 1'b0;
    if (rq) begin
      if (cd0 == 0 && free_s >= 0) begin
        m_valid[free_s] = 1; m_row[free_s] = ROWS - 2; m_col[free_s] = int'(playPos);
        m_cd = COOLDOWN;
      end else begin
        e.sd = 1'b1;
      end
    end
    cnt = 0;
    for (int s = 0; s < NUM_SLOTS; s++) cnt += m_valid[s];
    e.ac = 4'(cnt);
  endtask

  task automatic cycle();
    exp_t e;
    if (!rst) begin
      e.rb = '0; e.ac = '0; e.sd = 1'b0;
      model_reset();
    end else begin
      model_step(e);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("row_bits", 32'(row_bits), 32'(e.rb));
    check("active_cnt", 32'(active_cnt), 32'(e.ac));
    check("shot_drop", 32'(shot_drop), 32'(e.sd));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      scan_row = scan_row + 4'd1;
      cycle();
    end
  endtask

  task automatic shoot(input int pos);
    playPos = 3'(pos);
    fire    = ~fire;
    $display("shot pos=%0d fire=%0b t=%0t", pos, fire, $time);
    cycle();
  endtask

  initial begin
    int k;
    bit found;
    model_reset();

    // 1: reset held, inputs wiggled; then idle after release
    for (int i = 0; i < 6; i++) begin
      fire = ~fire; scan_row = 4'(i + 10); playPos = 3'(i);
      cycle();
    end
    check("t1_rst_cnt", 32'(active_cnt), 32'd0);
    fire = 1'b0;
    rst  = 1'b1;
    run(100);
    check("t1_idle_cnt", 32'(active_cnt), 32'd0);

    // 2: single shot at col 3
    shoot(3);
    check("t2_cnt", 32'(active_cnt), 32'd1);
    scan_row = 4'd14;
    cycle();
    check("t2_row14", 32'(row_bits), 32'h08);
    run(64);
    check("t2_retired", 32'(active_cnt), 32'd0);

    // 3: fill the pool, fifth shot is dropped
    shoot(1); run(11); shoot(2); run(11); shoot(5); run(11); shoot(6);
    check("t3_full", 32'(active_cnt), 32'd4);
    run(11);
    shoot(4);
    check("t3_drop", 32'(shot_drop), 32'd1);
    check("t3_cnt", 32'(active_cnt), 32'd4);
    run(1);
    check("t3_drop_pulse", 32'(shot_drop), 32'd0);
    run(80);
    check("t3_empty", 32'(active_cnt), 32'd0);

    // 4: cooldown rejects a quick second toggle, later toggle accepted
    shoot(2); run(3);
    shoot(3);
    check("t4_cool_drop", 32'(shot_drop), 32'd1);
    run(7);
    shoot(4);
    check("t4_accept", 32'(shot_drop), 32'd0);
    check("t4_cnt", 32'(active_cnt), 32'd2);
    scan_row = 4'd14;
    cycle();
    check("t4_row14", 32'(row_bits), 32'h10);
    run(80);

    // 5: request on the tick that retires slot0 while the pool is full
    shoot(1); run(11); shoot(2); run(11); shoot(3); run(11); shoot(4);
    found = 1'b0;
    k = 0;
    while (!found && k < 200) begin
      if (m_valid[0] != 0 && m_row[0] == 0 && m_div == STEP_DIV - 1) found = 1'b1;
      else begin scan_row = 4'd0; cycle(); k++; end
    end
    check("t5_align", 32'(found), 32'd1);
    shoot(5);
    check("t5_drop", 32'(shot_drop), 32'd1);
    check("t5_cnt", 32'(active_cnt), 32'd3);
    shoot(6);
    check("t5_refill", 32'(active_cnt), 32'd4);
    scan_row = 4'd14;
    cycle();
    check("t5_row14", 32'(row_bits), 32'h40);
    run(80);

    // 6: asynchronous reset with bullets in flight
    shoot(1); run(11); shoot(2); run(11); shoot(3); run(5);
    scan_row = 4'(m_row[0]);
    cycle();
    check("t6_pre_cnt", 32'(active_cnt), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("t6_async_cnt", 32'(active_cnt), 32'd0);
    check("t6_async_rows", 32'(row_bits), 32'd0);
    check("t6_async_drop", 32'(shot_drop), 32'd0);
    model_reset();
    fire = 1'b0;
    cycle(); cycle(); cycle();
    rst = 1'b1;
    shoot(2);
    check("t6_respawn", 32'(active_cnt), 32'd1);
    scan_row = 4'd14;
    cycle();
    check("t6_row14", 32'(row_bits), 32'h04);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
